// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA job scheduler: FSM states,
// requester indices and the length of the unit clear phase.
package rsa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_DONE,
        ST_ABORT
    } state_t;

    localparam logic REQ_GPIO     = 1'b0;
    localparam logic REQ_SPI      = 1'b1;
    localparam int   CLEAR_CYCLES = 2;

endpackage

// File: rtl/rsa_job_scheduler_if.sv
// Requester-facing and RSA-unit-facing signals of the job scheduler.
// master = the scheduler, slave = requesters plus RSA unit.
interface rsa_job_scheduler_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req_start;
    logic [1:0]       req_stop;
    logic             irq_ack;
    logic             rsa_eoc;
    logic [WIDTH-1:0] rsa_c;
    logic             rsa_en;
    logic             rsa_rstb;
    logic [WIDTH-1:0] result;
    logic             result_owner;
    logic [1:0]       pending;
    logic             busy;
    logic             done_irq;
    logic             timeout_err;

    modport master (
        input  req_start, req_stop, irq_ack, rsa_eoc, rsa_c,
        output rsa_en, rsa_rstb, result, result_owner, pending, busy,
               done_irq, timeout_err
    );

    modport slave (
        output req_start, req_stop, irq_ack, rsa_eoc, rsa_c,
        input  rsa_en, rsa_rstb, result, result_owner, pending, busy,
               done_irq, timeout_err
    );
endinterface

// File: rtl/rsa_rr_arbiter.sv
// Two-way round-robin arbiter: combinational grant, registered last owner.
// On a tie the requester that did not win last time is granted.
module rsa_rr_arbiter
    import rsa_pkg::*;
(
    input  logic       clk,
    input  logic       rstb,
    input  logic       ena,
    input  logic [1:0] pending,
    input  logic       take,
    output logic       grant_vld,
    output logic       grant_idx
);
    logic last_owner;

    always_comb begin
        grant_vld = |pending;
        grant_idx = REQ_GPIO;
        if (pending[REQ_GPIO] && pending[REQ_SPI])
            grant_idx = ~last_owner;
        else if (pending[REQ_SPI])
            grant_idx = REQ_SPI;
    end

    // Reset to SPI so GPIO wins the first tie.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb)
            last_owner <= REQ_SPI;
        else if (ena && take)
            last_owner <= grant_idx;
    end
endmodule

// File: rtl/rsa_job_scheduler.sv
// Shares one RSA unit between GPIO and SPI requesters: queues starts,
// sequences clear/run/done, latches results and enforces a run watchdog.
module rsa_job_scheduler
    import rsa_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int TIMEOUT_W      = 12,
    parameter int TIMEOUT_CYCLES = 4095
) (
    input logic                 clk,
    input logic                 rstb,
    input logic                 ena,
    rsa_job_scheduler_if.master bus
);
    localparam logic [1:0]           CLR_LAST = 2'(CLEAR_CYCLES - 1);
    localparam logic [TIMEOUT_W-1:0] WD_LAST  = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state_q, state_d;
    logic [1:0]           pending_q, pending_d;
    logic                 owner_q;
    logic [1:0]           clr_cnt_q;
    logic [TIMEOUT_W-1:0] wdog_q;
    logic                 timeout_err_q;
    logic [WIDTH-1:0]     result_q;
    logic                 result_owner_q;
    logic                 rsa_en_q, rsa_rstb_q, busy_q, done_irq_q;
    logic                 rsa_en_d, rsa_rstb_d, busy_d, done_irq_d;
    logic                 grant_vld, grant_idx, take, wdog_expired, run_eoc;

    assign take         = (state_q == ST_IDLE) && grant_vld;
    assign wdog_expired = (wdog_q == WD_LAST);
    assign run_eoc      = (state_q == ST_RUN) && bus.rsa_eoc;

    // A stop arriving in the same cycle as the grant cancels the request.
    rsa_rr_arbiter u_arb (
        .clk       (clk),
        .rstb      (rstb),
        .ena       (ena),
        .pending   (pending_q & ~bus.req_stop),
        .take      (take),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q    <= ST_IDLE;
            rsa_en_q   <= 1'b0;
            rsa_rstb_q <= 1'b0;
            busy_q     <= 1'b0;
            done_irq_q <= 1'b0;
        end else if (ena) begin
            state_q    <= state_d;
            rsa_en_q   <= rsa_en_d;
            rsa_rstb_q <= rsa_rstb_d;
            busy_q     <= busy_d;
            done_irq_q <= done_irq_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (grant_vld) state_d = ST_CLEAR;
            ST_CLEAR: if (clr_cnt_q == CLR_LAST) state_d = ST_RUN;
            ST_RUN: begin
                if (bus.rsa_eoc)
                    state_d = ST_DONE;
                else if (wdog_expired || bus.req_stop[owner_q])
                    state_d = ST_ABORT;
            end
            ST_DONE:  if (bus.irq_ack) state_d = ST_IDLE;
            ST_ABORT: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register with it.
    always_comb begin
        rsa_en_d   = 1'b0;
        rsa_rstb_d = 1'b0;
        busy_d     = 1'b1;
        done_irq_d = 1'b0;
        unique case (state_d)
            ST_IDLE: busy_d = 1'b0;
            ST_RUN: begin
                rsa_en_d   = 1'b1;
                rsa_rstb_d = 1'b1;
            end
            ST_DONE: begin
                rsa_rstb_d = 1'b1;
                done_irq_d = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        for (int i = 0; i < 2; i++) begin
            if (bus.req_stop[i])
                pending_d[i] = 1'b0;
            else if (take && grant_idx == 1'(i))
                pending_d[i] = 1'b0;
            else if (bus.req_start[i])
                pending_d[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            pending_q      <= '0;
            owner_q        <= REQ_GPIO;
            clr_cnt_q      <= '0;
            wdog_q         <= '0;
            timeout_err_q  <= 1'b0;
            result_q       <= '0;
            result_owner_q <= 1'b0;
        end else if (ena) begin
            pending_q <= pending_d;
            if (take)
                owner_q <= grant_idx;
            clr_cnt_q <= (state_q == ST_CLEAR) ? clr_cnt_q + 2'd1 : '0;
            // Zero outside RUN, so every entry to RUN starts from 0; saturates.
            if (state_q != ST_RUN)
                wdog_q <= '0;
            else if (wdog_q != '1)
                wdog_q <= wdog_q + TIMEOUT_W'(1);
            if (run_eoc) begin
                result_q       <= bus.rsa_c;
                result_owner_q <= owner_q;
            end
            if (state_q == ST_RUN && !bus.rsa_eoc && wdog_expired)
                timeout_err_q <= 1'b1;
            else if (bus.irq_ack)
                timeout_err_q <= 1'b0;
        end
    end

    assign bus.rsa_en       = rsa_en_q;
    assign bus.rsa_rstb     = rsa_rstb_q;
    assign bus.busy         = busy_q;
    assign bus.done_irq     = done_irq_q;
    assign bus.pending      = pending_q;
    assign bus.result       = result_q;
    assign bus.result_owner = result_owner_q;
    assign bus.timeout_err  = timeout_err_q;
endmodule

// File: doc/rsa_job_scheduler.md
Name: rsa_job_scheduler

Overview:
Controller that shares the single RSA datapath unit between two requesters: GPIO (index 0) and SPI (index 1).
- Queues start requests, arbitrates round-robin and sequences the unit (clear, enable, wait for end-of-conversion).
- Latches the result and owner, and raises a level interrupt until acknowledged.
- Enforces a watchdog timeout and per-requester abort.
- Sits between the GPIO/SPI command wrappers and the RSA unit instance in the top level.

Parameters:
WIDTH, 8, RSA operand/result width in bits.
TIMEOUT_W, 12, width of the RUN-state watchdog counter.
TIMEOUT_CYCLES, 4095, RUN cycles without rsa_eoc before abort with error; must be ≤ 2^TIMEOUT_W-1.

Ports:
clk  in  1  system clock, rising edge.
rstb  in  1  reset, asynchronous, active-low.
ena  in  1  design enable; when 0 all state, pending bits and counters hold.
req_start  in  2  single-cycle start pulses; bit0 GPIO, bit1 SPI.
req_stop  in  2  single-cycle stop pulses, same indexing.
irq_ack  in  1  single-cycle acknowledge; clears done_irq and timeout_err.
rsa_eoc  in  1  end-of-conversion from the RSA unit.
rsa_c  in  WIDTH  RSA unit result.
rsa_en  out  1  RSA unit enable.
rsa_rstb  out  1  RSA unit reset, active-low, synchronous to clk.
result  out  WIDTH  latched result of the last completed job.
result_owner  out  1  requester index of the last completed job.
pending  out  2  queued-request flags.
busy  out  1  high in any state other than IDLE.
done_irq  out  1  level interrupt, high in DONE.
timeout_err  out  1  sticky watchdog error flag.

Behaviour:
- Reset values: rsa_en=0, rsa_rstb=0, result=0, result_owner=0, pending=0, busy=0, done_irq=0, timeout_err=0, last_owner=1 (GPIO wins the first tie), FSM=IDLE.
- Reset is immediate (async). rsa_rstb stays low in IDLE, so the unit is held reset while unused.
- All outputs are registered (Moore).
- pending[i], per clock with ena=1:
  - set on req_start[i];
  - cleared on req_stop[i]; stop wins if start and stop arrive in the same cycle;
  - cleared when granted.
  - A start to an already pending requester is absorbed; no double-queue.
- FSM states: IDLE, CLEAR, RUN, DONE, ABORT.
- IDLE: if any pending bit is set, grant and go to CLEAR.
  - One bit set: that requester is granted.
  - Both set: the requester != last_owner is granted.
  - The grant updates owner and last_owner and clears its pending bit.
- CLEAR: lasts exactly 2 cycles with rsa_rstb=0 and rsa_en=0, then RUN.
  - Latency: req_start in cycle T, then pending visible at T+1, CLEAR at T+2..T+3, RUN (rsa_en=1, rsa_rstb=1) from T+4.
- RUN: rsa_en=1, rsa_rstb=1, watchdog counts from 0.
  - rsa_eoc=1 → latch result<=rsa_c and result_owner<=owner, go to DONE.
  - Watchdog reaches TIMEOUT_CYCLES with no eoc → timeout_err<=1, go to ABORT.
  - req_stop[owner] → ABORT; no result update, no irq.
  - If eoc and stop[owner] occur in the same cycle, eoc wins.
  - rsa_eoc is ignored outside RUN.
- DONE: rsa_en=0, rsa_rstb=1 (result held), done_irq=1. On irq_ack: done_irq<=0, go to IDLE. New starts queue in pending meanwhile.
- ABORT: 1 cycle with rsa_en=0 and rsa_rstb=0, then IDLE.
- timeout_err is cleared only by irq_ack, which is accepted in any state.
- req_stop to a non-owner, or while in DONE, only clears that requester's pending bit.
- Watchdog saturates (never wraps) and resets on each entry to RUN.

Decomposition:
- Shared package rsa_pkg: the state enum (IDLE, CLEAR, RUN, DONE, ABORT), requester index constants REQ_GPIO=0 and REQ_SPI=1, and the CLEAR_CYCLES=2 constant.
- One natural sub-module, rsa_rr_arbiter: 2-way round-robin grant from pending and last_owner. Combinational grant plus the registered last_owner.
- FSM, pending register and watchdog stay in the top module.

Test Plan:
1. Reset, then GPIO start pulse at cycle 10; behavioural RSA model asserts eoc with C=0x2A after 20 RUN cycles → rsa_en rises at cycle 14; result=0x2A, result_owner=0, done_irq=1 until irq_ack; busy=0 one cycle after ack.
2. GPIO and SPI start in the same cycle after reset → GPIO served first, SPI pending=2'b10 during the job; after ack, SPI runs and result_owner=1.
3. Model never asserts eoc, TIMEOUT_CYCLES=16 → after 16 RUN cycles timeout_err=1, one ABORT cycle with rsa_rstb=0, then IDLE; done_irq stays 0; irq_ack clears timeout_err.
4. SPI stop 5 cycles into an SPI job → ABORT next cycle, result unchanged from the prior value, no irq. Also: start and stop for SPI in the same cycle → pending stays 0.
5. ena=0 held for 10 cycles mid-RUN → watchdog, state and rsa_en frozen; the job resumes and completes normally when ena returns to 1.
6. rstb pulsed low mid-RUN → all outputs return to reset values immediately (asynchronously), pending=0; the next start runs normally.
